int_mult_arbiter: RTL

Round-robin arbiter that shares one signed integer multiplier among `NUM_REQ` requesters. It sits between several low-rate datapath clients and a single multiply resource, with a registered, back-pressured result port. Each result carries the index of the requester that issued it. Throughput is one product per cycle when the result port is not stalled.

---
 rtl/int_mult_arbiter_if.sv | 36 +++
 rtl/int_mult_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/int_mult_arbiter_if.sv
// Purpose : requester/result bundle for int_mult_arbiter.
// Latency : n/a (wires only).
// Backpressure: req_ready per requester, out_ready from the consumer.
//
// Port summary:
//   req_valid/req_ready  per-requester handshake (bit i = requester i)
//   req_a/req_b          packed signed operands, slice i at [i*W +: W]
//   out_valid/out_ready  registered result handshake
//   out_data/out_id      full-precision product and issuing requester index
interface int_mult_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [A_WIDTH+B_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]        out_id;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/int_mult_arbiter.sv
// Purpose : round-robin share of one signed multiplier among NUM_REQ requesters.
// Latency : 1 cycle handshake-to-result; 2 cycles with INT_MULT_ARB_INPUT_REG_EN defined.
// Backpressure: out_ready stalls the result register; req_ready drops while the pipe is full.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; also masks req_ready while low
//   bus    int_mult_arbiter_if.slave (request handshakes, operands, result port)
//
// Optional build macro INT_MULT_ARB_INPUT_REG_EN inserts a registered operand
// stage ahead of the multiplier; handshake, fairness and reset behave the same.
module int_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  int_mult_arbiter_if.slave   bus
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

  // Sign-extend both operands to the full product width first, so the
  // truncated product is the exact signed result (including -2^(A-1) * -2^(B-1)).
  function automatic logic [P_WIDTH-1:0] smul(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b
  );
    logic signed [P_WIDTH-1:0] ae;
    logic signed [P_WIDTH-1:0] be;
    logic signed [P_WIDTH-1:0] p;
    ae = {{B_WIDTH{a[A_WIDTH-1]}}, a};
    be = {{A_WIDTH{b[B_WIDTH-1]}}, b};
    p  = ae * be;
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] cand_idx;
  logic                grant_any;
  logic                accept;
  logic                fire;

  // Scan from the highest offset down so the last hit, which wins, is the
  // lowest offset from rr_ptr, i.e. the first valid requester going upward.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // rst_n gates the handshake so nothing is accepted in a reset cycle.
  assign fire = grant_any && accept && rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (fire) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Operands of the granted requester, sampled only on a handshake.
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  assign sel_a = bus.req_a[int'(grant_idx) * A_WIDTH +: A_WIDTH];
  assign sel_b = bus.req_b[int'(grant_idx) * B_WIDTH +: B_WIDTH];

  // ---------------------------------------------------------------------------
  // Multiplier feed: either straight from the arbiter or via an operand stage
  // ---------------------------------------------------------------------------
  logic [A_WIDTH-1:0]  mul_a;
  logic [B_WIDTH-1:0]  mul_b;
  logic [ID_WIDTH-1:0] mul_id;
  logic                mul_valid;
  logic                load_en;   // output register may take a new value

`ifdef INT_MULT_ARB_INPUT_REG_EN
  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;
  logic                out_accept;

  assign out_accept = !bus.out_valid || bus.out_ready;
  // The operand stage can take a new pair if it is empty or is moving on
  // into the output register this cycle; that keeps one pair per cycle.
  assign accept     = !s1_valid || out_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= fire;
      if (fire) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= grant_idx;
      end
    end
  end

  assign mul_a     = s1_a;
  assign mul_b     = s1_b;
  assign mul_id    = s1_id;
  assign mul_valid = s1_valid;
  assign load_en   = out_accept;
`else
  assign accept    = !bus.out_valid || bus.out_ready;
  assign mul_a     = sel_a;
  assign mul_b     = sel_b;
  assign mul_id    = grant_idx;
  assign mul_valid = fire;
  assign load_en   = accept;
`endif

  // ---------------------------------------------------------------------------
  // Result register: holds while out_valid && !out_ready; reloads with no
  // bubble when a drain and a new product coincide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else if (load_en) begin
      bus.out_valid <= mul_valid;
      if (mul_valid) begin
        bus.out_data <= smul(mul_a, mul_b);
        bus.out_id   <= mul_id;
      end
    end
  end

endmodule
